// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one i2c_master among NUM_REQ requesters,
// with NACK retry and a per-transaction timeout.
module i2c_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [NUM_REQ-1:0]     rsp_err,
  output logic                   timeout_evt,
  output logic                   m_start_req,
  output logic [6:0]             m_slave_addr,
  output logic                   m_rw_bit,
  output logic [7:0]             m_data_in,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic                   m_ack_error
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d, rsp_err_d;
  logic               timeout_evt_d, m_start_req_d, m_rw_bit_d;
  logic [6:0]         m_slave_addr_d;
  logic [7:0]         m_data_in_d;

  logic [6:0]         addr_arr [NUM_REQ];
  logic [7:0]         data_arr [NUM_REQ];
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] cur_vec;

  // Unpack the flat per-requester buses
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[7*gi +: 7];
    assign data_arr[gi] = req_data[8*gi +: 8];
  end

  assign cur_vec = NUM_REQ'(1) << cur_q;

  // Round-robin search starting just after the last served requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    last_d         = last_q;
    retry_d        = retry_q;
    timer_d        = timer_q;
    m_start_req_d  = m_start_req;
    m_slave_addr_d = m_slave_addr;
    m_rw_bit_d     = m_rw_bit;
    m_data_in_d    = m_data_in;
    req_ready_d    = '0;
    rsp_valid_d    = '0;
    rsp_err_d      = '0;
    timeout_evt_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          cur_d          = grant_idx;
          m_slave_addr_d = addr_arr[grant_idx];
          m_rw_bit_d     = req_rw[grant_idx];
          m_data_in_d    = data_arr[grant_idx];
          req_ready_d    = NUM_REQ'(1) << grant_idx;
          m_start_req_d  = 1'b1;
          retry_d        = '0;
          timer_d        = '0;
          state_d        = LAUNCH;
        end
      end

      LAUNCH, WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // Completion takes priority over both timeout and the busy handshake
        if (m_done) begin
          if (m_ack_error && (32'(retry_q) < MAX_RETRY)) begin
            retry_d       = retry_q + RTY_W'(1);
            m_start_req_d = 1'b1;
            state_d       = LAUNCH;
          end else begin
            m_start_req_d = 1'b0;
            rsp_valid_d   = cur_vec;
            rsp_err_d     = m_ack_error ? cur_vec : '0;
            state_d       = RESP;
          end
        end else if (32'(timer_q) >= TIMEOUT_CYCLES - 1) begin
          m_start_req_d = 1'b0;
          timeout_evt_d = 1'b1;
          rsp_valid_d   = cur_vec;
          rsp_err_d     = cur_vec;
          state_d       = RESP;
        end else if ((state_q == LAUNCH) && m_busy) begin
          m_start_req_d = 1'b0;
          state_d       = WAIT;
        end
      end

      RESP: begin
        last_d  = cur_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      last_q       <= IDX_W'(NUM_REQ - 1);
      retry_q      <= '0;
      timer_q      <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_err      <= '0;
      timeout_evt  <= 1'b0;
      m_start_req  <= 1'b0;
      m_slave_addr <= '0;
      m_rw_bit     <= 1'b0;
      m_data_in    <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      req_ready    <= req_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_err      <= rsp_err_d;
      timeout_evt  <= timeout_evt_d;
      m_start_req  <= m_start_req_d;
      m_slave_addr <= m_slave_addr_d;
      m_rw_bit     <= m_rw_bit_d;
      m_data_in    <= m_data_in_d;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: grant order, retry, timeout, reset abort
// and same-cycle busy/done handling, against hand-computed expectations.
module tb_i2c_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [27:0] req_addr;
  logic [3:0]  req_rw;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_err;
  logic        timeout_evt;
  logic        m_start_req;
  logic [6:0]  m_slave_addr;
  logic        m_rw_bit;
  logic [7:0]  m_data_in;
  logic        m_busy;
  logic        m_done;
  logic        m_ack_error;

  int passed = 0;
  int total  = 0;

  i2c_arbiter #(.NUM_REQ(4), .MAX_RETRY(2), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .timeout_evt(timeout_evt),
    .m_start_req(m_start_req), .m_slave_addr(m_slave_addr), .m_rw_bit(m_rw_bit),
    .m_data_in(m_data_in), .m_busy(m_busy), .m_done(m_done), .m_ack_error(m_ack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Wait (bounded) at falling edges for a grant pulse
  task automatic wait_ready(output logic [3:0] rdy);
    int n;
    n = 0;
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    rdy = req_ready;
  endtask

  // Master model: answer `attempts` launches, NACKing the first `nacks`
  task automatic serve(input int attempts, input int nacks, input bit same,
                       output int launches, output logic [3:0] rv, output logic [3:0] re);
    int n;
    launches = 0;
    rv = '0;
    re = '0;
    for (int a = 0; a < attempts; a++) begin
      n = 0;
      while (!m_start_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!m_start_req) break;
      launches++;
      m_busy = 1'b1;
      if (!same) begin
        @(negedge clk);
        @(negedge clk);
        m_busy = 1'b0;
      end
      m_done      = 1'b1;
      m_ack_error = (a < nacks);
      @(negedge clk);
      rv = rsp_valid;
      re = rsp_err;
      m_done      = 1'b0;
      m_ack_error = 1'b0;
      m_busy      = 1'b0;
    end
  endtask

  // OR of m_start_req over a few cycles, to catch a spurious relaunch
  task automatic idle_start(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | m_start_req;
    end
  endtask

  initial begin
    logic [3:0] rdy, rv, re, exp_vec, any_rsp;
    int launches, k;
    logic seen;

    rst = 1'b1; req_valid = '0; req_rw = '0;
    m_busy = 1'b0; m_done = 1'b0; m_ack_error = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[7*i +: 7] = 7'(8'h10 + i);
      req_data[8*i +: 8] = 8'(8'hC0 + i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start", 32'(m_start_req), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rsp",   32'(rsp_valid), 32'h0);
    check("rst_addr",  32'(m_slave_addr), 32'h0);
    check("rst_tmo",   32'(timeout_evt), 32'h0);

    // Single requester 1, exact one-cycle grant latency
    rst = 1'b0;
    req_addr[13:7] = 7'h34; req_rw[1] = 1'b0; req_data[15:8] = 8'hAA;
    req_valid = 4'b0010;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h2);
    check("t1_start", 32'(m_start_req), 32'h1);
    check("t1_addr",  32'(m_slave_addr), 32'h34);
    check("t1_data",  32'(m_data_in), 32'hAA);
    check("t1_rw",    32'(m_rw_bit), 32'h0);
    req_valid = 4'b0; req_addr[13:7] = 7'h55; req_data[15:8] = 8'h11;
    @(negedge clk);
    check("t1_pulse", 32'(req_ready), 32'h0);
    serve(1, 0, 1'b0, launches, rv, re);
    check("t1_rsp",   32'(rv), 32'h2);
    check("t1_err",   32'(re), 32'h0);
    check("t1_hold",  32'(m_slave_addr), 32'h34);

    // Round robin from reset priority with all four requesting
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req_addr[7*i +: 7] = 7'(8'h10 + i);
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_vec = 4'b0001 << (t % 4);
      wait_ready(rdy);
      check($sformatf("rr%0d_grant", t), 32'(rdy), 32'(exp_vec));
      check($sformatf("rr%0d_addr", t), 32'(m_slave_addr), 32'h10 + 32'(t % 4));
      if (t == 7) req_valid = 4'b0;
      serve(1, 0, 1'b0, launches, rv, re);
      check($sformatf("rr%0d_rsp", t), 32'(rv), 32'(exp_vec));
    end

    // NACK on every attempt: three launches then error
    req_valid = 4'b0100;
    wait_ready(rdy);
    check("nack_grant", 32'(rdy), 32'h4);
    req_valid = 4'b0;
    serve(3, 3, 1'b0, launches, rv, re);
    check("nack_launches", 32'(launches), 32'd3);
    check("nack_rsp", 32'(rv), 32'h4);
    check("nack_err", 32'(re), 32'h4);
    idle_start(seen);
    check("nack_no_extra", 32'(seen), 32'h0);

    // NACK then ACK: two launches, no error
    req_valid = 4'b0100;
    wait_ready(rdy);
    req_valid = 4'b0;
    serve(2, 1, 1'b0, launches, rv, re);
    check("retry_launches", 32'(launches), 32'd2);
    check("retry_rsp", 32'(rv), 32'h4);
    check("retry_err", 32'(re), 32'h0);
    idle_start(seen);
    check("retry_no_extra", 32'(seen), 32'h0);

    // busy and done in the same launch cycle
    req_valid = 4'b1000;
    wait_ready(rdy);
    check("same_grant", 32'(rdy), 32'h8);
    req_valid = 4'b0;
    serve(1, 0, 1'b1, launches, rv, re);
    check("same_rsp", 32'(rv), 32'h8);
    check("same_err", 32'(re), 32'h0);
    idle_start(seen);
    check("same_no_extra", 32'(seen), 32'h0);

    // Silent master: timeout 50 cycles after launch entry
    req_valid = 4'b0001;
    wait_ready(rdy);
    check("tmo_grant", 32'(rdy), 32'h1);
    req_valid = 4'b0;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (timeout_evt) begin
        k = i;
        break;
      end
    end
    check("tmo_cycle", 32'(k), 32'd50);
    check("tmo_rsp",   32'(rsp_valid), 32'h1);
    check("tmo_err",   32'(rsp_err), 32'h1);
    check("tmo_start", 32'(m_start_req), 32'h0);
    @(negedge clk);
    check("tmo_pulse", 32'(timeout_evt), 32'h0);

    // Reset mid-WAIT aborts; later done ignored; requester 0 first again
    req_valid = 4'b0010;
    wait_ready(rdy);
    check("abort_grant", 32'(rdy), 32'h2);
    req_valid = 4'b0;
    m_busy = 1'b1;
    @(negedge clk);
    rst = 1'b1; m_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0; m_done = 1'b1;
    check("abort_start", 32'(m_start_req), 32'h0);
    any_rsp = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_done = 1'b0;
      any_rsp = any_rsp | rsp_valid;
    end
    check("abort_no_rsp", 32'(any_rsp), 32'h0);
    req_valid = 4'b0011;
    wait_ready(rdy);
    check("abort_prio", 32'(rdy), 32'h1);
    req_valid = 4'b0;
    serve(1, 0, 1'b0, launches, rv, re);
    check("abort_next_rsp", 32'(rv), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, the number of requesters sharing one i2c_master.
REQ-002 SHALL provide parameter MAX_RETRY, default 2, the number of re-launches allowed after an ack_error.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 200000, the per-transaction clk-cycle limit.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester transaction request, level.
REQ-007 SHALL have port req_addr  input  7*NUM_REQ  slave address, requester i at bits [7i+6:7i].
REQ-008 SHALL have port req_rw  input  NUM_REQ  rw bit per requester.
REQ-009 SHALL have port req_data  input  8*NUM_REQ  write byte, requester i at bits [8i+7:8i].
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-cycle accept pulse, one-hot or zero.
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  one-cycle completion pulse, one-hot or zero.
REQ-012 SHALL have port rsp_err  output  NUM_REQ  error status, valid only with the matching rsp_valid bit.
REQ-013 SHALL have port timeout_evt  output  1  one-cycle pulse when a transaction times out.
REQ-014 SHALL have port m_start_req  output  1  to i2c_master start_req.
REQ-015 SHALL have port m_slave_addr  output  7  to i2c_master slave_addr.
REQ-016 SHALL have port m_rw_bit  output  1  to i2c_master rw_bit.
REQ-017 SHALL have port m_data_in  output  8  to i2c_master data_in.
REQ-018 SHALL have port m_busy  input  1  from i2c_master busy.
REQ-019 SHALL have port m_done  input  1  from i2c_master done.
REQ-020 SHALL have port m_ack_error  input  1  from i2c_master ack_error, sampled with m_done.

Function
REQ-021 SHALL implement the FSM states IDLE, LAUNCH, WAIT and RESP; all outputs SHALL be registered.
REQ-022 IDLE: if any req_valid is set, SHALL grant round-robin, searching from last_grant+1 modulo NUM_REQ, SHALL latch that requester's addr/rw/data into m_slave_addr, m_rw_bit and m_data_in, SHALL pulse req_ready[g] in the next cycle, SHALL clear retry_cnt and timer, and SHALL go to LAUNCH.
REQ-023 LAUNCH: SHALL hold m_start_req=1 until m_busy=1 or m_done=1 is sampled, then SHALL drive m_start_req=0 and go to WAIT; if both are sampled in the same cycle, SHALL process m_done per REQ-024 in that cycle.
REQ-024 WAIT: on m_done with m_ack_error=0, SHALL go to RESP with err=0. On m_done with m_ack_error=1 and retry_cnt<MAX_RETRY, SHALL increment retry_cnt and return to LAUNCH. On m_done with m_ack_error=1 and retry_cnt=MAX_RETRY, SHALL go to RESP with err=1.
REQ-025 Timer SHALL count every cycle in LAUNCH and WAIT, and SHALL NOT be cleared by retries; when it reaches TIMEOUT_CYCLES-1, SHALL pulse timeout_evt, drop m_start_req and go to RESP with err=1. If timeout and m_done occur in the same cycle, m_done SHALL win.
REQ-026 RESP: SHALL pulse rsp_valid[g] for one cycle with rsp_err[g]=err, SHALL set last_grant=g, and SHALL return to IDLE; a new grant SHALL NOT occur before the next IDLE cycle.
REQ-027 Master inputs SHALL be held stable from grant until RESP; req_* changes after req_ready SHALL have no effect.
REQ-028 A req_valid deasserted before grant SHALL be dropped silently; m_done outside LAUNCH/WAIT SHALL be ignored.
REQ-029 Latency: req_valid sampled in IDLE at edge t SHALL give req_ready at t+1 and m_start_req=1 from t+1.

Reset
REQ-030 rst SHALL force IDLE and zero on m_start_req, req_ready, rsp_valid, rsp_err, timeout_evt, m_slave_addr, m_rw_bit, m_data_in, retry_cnt and timer, and SHALL set last_grant=NUM_REQ-1 so requester 0 has first priority.
REQ-031 rst during LAUNCH/WAIT SHALL abort the transaction with no rsp_valid; any later m_done SHALL be ignored.

Verification
REQ-032 Single requester 1 with addr 0x34, rw 0, data 0xAA -> req_ready=0010 next cycle, m_slave_addr=0x34, m_data_in=0xAA, one m_done with ack_error=0 -> rsp_valid=0010, rsp_err=0.
REQ-033 All four req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Model NACKs every attempt, MAX_RETRY=2 -> exactly 3 m_start_req launches, then rsp_err=1; NACK then ACK -> 2 launches, rsp_err=0.
REQ-035 TIMEOUT_CYCLES=50 with m_done never asserted -> timeout_evt and rsp_valid with rsp_err=1 exactly 50 cycles after LAUNCH entry, m_start_req=0.
REQ-036 rst asserted mid-WAIT, then m_done -> no rsp_valid; next request from requester 0 is granted first.
REQ-037 m_busy and m_done asserted in the same LAUNCH cycle -> treated as completion, no extra launch.
